// File: rtl/gray2bin_tracker_pkg.sv
// Shared definitions for the Gray-to-binary tracker and its consumers:
// default widths, pipeline depth and the per-sample step classification.
package gray2bin_tracker_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int POS_W_DEF = 16;
  localparam int ERR_W_DEF = 8;
  localparam int STAGES    = 2;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_SKIP = 2'd3
  } step_e;

endpackage

// File: rtl/gray2bin_tracker_if.sv
// Sample-in / decoded-out bundle of the tracker; the sampler side holds the
// master modport, the tracker holds the slave modport.
interface gray2bin_tracker_if
  import gray2bin_tracker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int POS_W = POS_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) ();

  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] g_in;
  logic             out_valid;
  logic [WIDTH-1:0] b_out;
  logic             step_up;
  logic             step_dn;
  logic             skip_err;
  logic [POS_W-1:0] pos;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output clear, in_valid, g_in,
    input  out_valid, b_out, step_up, step_dn, skip_err, pos, err_cnt
  );

  modport slave (
    input  clear, in_valid, g_in,
    output out_valid, b_out, step_up, step_dn, skip_err, pos, err_cnt
  );

endinterface

// File: rtl/gray2bin_tracker_gray2bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above it (inverse of the team's binary-to-Gray encoder).
module gray2bin_tracker_gray2bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  logic acc;

  always_comb begin
    b_o = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ g_i[i];
      b_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray2bin_tracker.sv
// Two-stage Gray sample tracker: S1 registers the raw sample, S2 decodes it,
// classifies the step against the previous sample and updates pos/err_cnt.
module gray2bin_tracker
  import gray2bin_tracker_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int POS_W = POS_W_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  gray2bin_tracker_if.slave   bus
);

  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_DN = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [STAGES:1]  vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0] g_s1_q, g_s1_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             base_q, base_d;
  step_e            step_q, step_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] b_dec;
  logic [WIDTH-1:0] delta;

  gray2bin_tracker_gray2bin #(.WIDTH(WIDTH)) u_dec (
    .g_i (g_s1_q),
    .b_o (b_dec)
  );

  // b_out_q doubles as the previous-sample reference: it only moves on
  // valid samples, including erroneous ones, which re-baselines the check.
  assign delta = b_dec - b_out_q;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.in_valid};
    g_s1_d     = bus.in_valid ? bus.g_in : g_s1_q;
    b_out_d    = b_out_q;
    base_d     = base_q;
    step_d     = STEP_NONE;
    pos_d      = pos_q;
    err_d      = err_q;

    if (vld_pipe_q[1]) begin
      b_out_d = b_dec;
      base_d  = 1'b1;
      if (base_q) begin
        if (delta == '0) begin
          step_d = STEP_NONE;
        end else if (delta == DELTA_UP) begin
          step_d = STEP_UP;
          pos_d  = pos_q + POS_W'(1);
        end else if (delta == DELTA_DN) begin
          step_d = STEP_DN;
          pos_d  = pos_q - POS_W'(1);
        end else begin
          step_d = STEP_SKIP;
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
        end
      end
    end

    // clear wins over everything, including a sample arriving this cycle
    if (bus.clear) begin
      vld_pipe_d = '0;
      g_s1_d     = '0;
      b_out_d    = '0;
      base_d     = 1'b0;
      step_d     = STEP_NONE;
      pos_d      = '0;
      err_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      g_s1_q     <= '0;
      b_out_q    <= '0;
      base_q     <= 1'b0;
      step_q     <= STEP_NONE;
      pos_q      <= '0;
      err_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      g_s1_q     <= g_s1_d;
      b_out_q    <= b_out_d;
      base_q     <= base_d;
      step_q     <= step_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[STAGES];
  assign bus.b_out     = b_out_q;
  assign bus.step_up   = (step_q == STEP_UP);
  assign bus.step_dn   = (step_q == STEP_DN);
  assign bus.skip_err  = (step_q == STEP_SKIP);
  assign bus.pos       = pos_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_gray2bin_tracker.sv
// Bench for gray2bin_tracker: two instances (8-bit and 2-bit error counter)
// share one stimulus stream and are checked against a sample-queue model.
module tb_gray2bin_tracker;
  import gray2bin_tracker_pkg::*;

  localparam int W   = 4;
  localparam int PW  = 16;
  localparam int EW0 = 8;
  localparam int EW1 = 2;
  localparam int MODW = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] g_in = '0;

  always #5 clk = ~clk;

  gray2bin_tracker_if #(.WIDTH(W), .POS_W(PW), .ERR_W(EW0)) bus0 ();
  gray2bin_tracker_if #(.WIDTH(W), .POS_W(PW), .ERR_W(EW1)) bus1 ();

  assign bus0.clear = clear;  assign bus0.in_valid = in_valid;  assign bus0.g_in = g_in;
  assign bus1.clear = clear;  assign bus1.in_valid = in_valid;  assign bus1.g_in = g_in;

  gray2bin_tracker #(.WIDTH(W), .POS_W(PW), .ERR_W(EW0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gray2bin_tracker #(.WIDTH(W), .POS_W(PW), .ERR_W(EW1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gray(input int b);
    logic [W-1:0] x;
    x = b[W-1:0];
    return x ^ (x >> 1);
  endfunction

  // binary bit i = parity of the Gray word shifted down by i
  function automatic int dec(input logic [W-1:0] g);
    int r;
    r = 0;
    for (int i = 0; i < W; i++) r = r | (int'(^(g >> i)) << i);
    return r;
  endfunction

  typedef struct { int unsigned due; logic [W-1:0] g; } smp_t;
  smp_t q[$];
  int unsigned edge_n = 0;
  bit m_base = 0;
  int m_prev = 0, m_pos = 0, m_err0 = 0, m_err1 = 0;
  bit e_vld = 0;
  int e_b = 0;
  int e_kind = 0;  // 0 none, 1 up, 2 down, 3 skip

  // Model: each accepted sample becomes visible one edge after it is taken.
  initial forever begin
    smp_t s;
    int b, d;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_base = 0; m_prev = 0; m_pos = 0; m_err0 = 0; m_err1 = 0;
      e_vld = 0; e_b = 0; e_kind = 0;
    end else begin
      edge_n++;
      e_vld = 0;
      e_kind = 0;
      if (clear) begin
        q.delete();
        m_base = 0; m_prev = 0; m_pos = 0; m_err0 = 0; m_err1 = 0;
      end else begin
        if (q.size() > 0 && q[0].due == edge_n) begin
          s = q.pop_front();
          b = dec(s.g);
          e_vld = 1;
          e_b = b;
          if (m_base) begin
            d = (b - m_prev + MODW) % MODW;
            if (d == 1) begin
              e_kind = 1; m_pos = (m_pos + 1) % (1 << PW);
            end else if (d == MODW - 1) begin
              e_kind = 2; m_pos = (m_pos + (1 << PW) - 1) % (1 << PW);
            end else if (d != 0) begin
              e_kind = 3;
              if (m_err0 < (1 << EW0) - 1) m_err0++;
              if (m_err1 < (1 << EW1) - 1) m_err1++;
            end
          end
          m_prev = b;
          m_base = 1;
        end
        if (in_valid) q.push_back('{edge_n + 1, g_in});
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("out_valid0", 32'(bus0.out_valid), 32'(e_vld));
    chk("out_valid1", 32'(bus1.out_valid), 32'(e_vld));
    if (e_vld) begin
      chk("b_out0", 32'(bus0.b_out), 32'(e_b));
      chk("b_out1", 32'(bus1.b_out), 32'(e_b));
    end
    chk("step_up",  32'(bus0.step_up),  32'(e_vld && e_kind == 1));
    chk("step_dn",  32'(bus0.step_dn),  32'(e_vld && e_kind == 2));
    chk("skip_err", 32'(bus0.skip_err), 32'(e_vld && e_kind == 3));
    chk("skip_err1", 32'(bus1.skip_err), 32'(e_vld && e_kind == 3));
    chk("pos0", 32'(bus0.pos), 32'(m_pos));
    chk("pos1", 32'(bus1.pos), 32'(m_pos));
    chk("err_cnt0", 32'(bus0.err_cnt), 32'(m_err0));
    chk("err_cnt1", 32'(bus1.err_cnt), 32'(m_err1));
  end

  task automatic step(input bit v, input logic [W-1:0] g, input bit c = 1'b0);
    @(negedge clk);
    in_valid = v;
    g_in = g;
    clear = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    int cur, r;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset pos", 32'(bus0.pos), 32'h0);
    chk("reset out_valid", 32'(bus0.out_valid), 32'h0);

    // count up 0..3 straight after reset; check the 2-cycle latency
    step(1, 4'b0000); step(1, 4'b0001);
    chk("T1 no early valid", 32'(bus0.out_valid), 32'h0);
    step(1, 4'b0011);
    chk("T1 first valid", 32'(bus0.out_valid), 32'h1);
    chk("T1 baseline no flag", 32'(bus0.step_up), 32'h0);
    step(1, 4'b0010);
    chk("T1 b_out 1", 32'(bus0.b_out), 32'h1);
    chk("T1 step_up", 32'(bus0.step_up), 32'h1);
    idle(3);
    chk("T1 pos", 32'(bus0.pos), 32'h3);
    chk("T1 err", 32'(bus0.err_cnt), 32'h0);

    // wrap 15->0 up, back down, then below zero
    step(0, 0, 1);
    step(1, 4'b1000); step(1, 4'b0000); step(1, 4'b1000); step(1, 4'b1001);
    idle(3);
    chk("T2 pos wrap", 32'(bus0.pos), 32'hFFFF);

    // skip then re-baselined step
    step(0, 0, 1);
    step(1, 4'b0000); step(1, 4'b0011); step(1, 4'b0010);
    idle(3);
    chk("T3 err", 32'(bus0.err_cnt), 32'h1);
    chk("T3 pos", 32'(bus0.pos), 32'h1);

    // repeat across a gap
    step(0, 0, 1);
    step(1, 4'b0001); idle(3); step(1, 4'b0001); step(1, 4'b0011);
    idle(3);
    chk("T4 pos", 32'(bus0.pos), 32'h1);

    // error counter saturation on the 2-bit instance: b 0,2,4,6,8
    step(0, 0, 1);
    step(1, gray(0)); step(1, gray(2)); step(1, gray(4)); step(1, gray(6)); step(1, gray(8));
    idle(3);
    chk("T5 err8", 32'(bus0.err_cnt), 32'h4);
    chk("T5 err2 sat", 32'(bus1.err_cnt), 32'h3);

    // clear with samples in flight
    step(1, gray(0)); step(1, gray(1)); step(1, gray(2)); step(1, gray(3), 1);
    step(0, 0);
    chk("T6 clr valid a", 32'(bus0.out_valid), 32'h0);
    chk("T6 clr pos", 32'(bus0.pos), 32'h0);
    chk("T6 clr err", 32'(bus0.err_cnt), 32'h0);
    step(1, gray(9));
    chk("T6 clr valid b", 32'(bus0.out_valid), 32'h0);
    idle(3);
    chk("T6 baseline pos", 32'(bus0.pos), 32'h0);

    // asynchronous reset in the middle of a cycle
    step(1, gray(10)); step(1, gray(11)); step(1, gray(12)); step(1, gray(13));
    idle(2);
    chk("T7 pre pos", 32'(bus0.pos), 32'h4);
    step(1, gray(14));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("T7 async pos", 32'(bus0.pos), 32'h0);
    chk("T7 async valid", 32'(bus0.out_valid), 32'h0);
    chk("T7 async err", 32'(bus1.err_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, gray(5)); idle(3);
    chk("T7 baseline pos", 32'(bus0.pos), 32'h0);

    // randomized walk: mostly single steps, some repeats, jumps, gaps, clears
    cur = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cur = (cur + 1) % MODW;
      else if (r < 7) cur = (cur + MODW - 1) % MODW;
      else if (r == 9) cur = $urandom_range(0, MODW - 1);
      step($urandom_range(0, 9) < 7, gray(cur), $urandom_range(0, 99) == 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
